// File: rtl/hex_display_scheduler.sv
// Chooses the 16-bit word shown on the 4-digit hex display: dwell-timed rotation, manual paging, alert pre-emption.
// Define HEX_SCHED_BLINK_EN to make the alert alternate with 16'hEEEE every BLINK_CYCLES.
module hex_display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int HOLD_CYCLES  = 100000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [16*NUM_SRC-1:0]      src_value,
    input  logic [NUM_SRC-1:0]         src_en,
    input  logic                       next_page,
    input  logic                       alert_req,
    input  logic [15:0]                alert_value,
    output logic                       alert_ack,
    output logic [3:0]                 disp_nibble [4],
    output logic [$clog2(NUM_SRC)-1:0] disp_src,
    output logic                       disp_alert,
    output logic                       disp_valid
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8 || DWELL_CYCLES < 1 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1)
    begin : g_bad_params
        $error("hex_display_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALERT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cur_q, cur_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [15:0]     alert_val_q, alert_val_d;
    logic            ack_q, ack_d;
    logic [15:0]     word_q, word_d;
    logic [SW-1:0]   src_q, src_d;
    logic            alert_q, alert_d;
    logic            valid_q, valid_d;
    logic            enter_alert;
    logic [15:0]     src_word [NUM_SRC];

`ifdef HEX_SCHED_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;
`endif

    function automatic logic [SW-1:0] next_enabled(input logic [SW-1:0] c,
                                                   input logic [NUM_SRC-1:0] en);
        logic [SW-1:0] r;
        logic          found;
        int            k;
        r     = c;
        found = 1'b0;
        for (int i = 1; i < NUM_SRC; i++) begin
            k = (int'(c) + i) % NUM_SRC;
            if (!found && en[k]) begin
                r     = SW'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] lowest_enabled(input logic [NUM_SRC-1:0] en);
        logic [SW-1:0] r;
        r = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (en[k]) r = SW'(k);
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_word[k] = src_value[16*k +: 16];
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        dwell_d     = dwell_q;
        hold_d      = hold_q;
        alert_val_d = alert_val_q;
        ack_d       = 1'b0;
        enter_alert = 1'b0;
`ifdef HEX_SCHED_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (alert_req) begin
                    enter_alert = 1'b1;
                end else if (|src_en) begin
                    state_d = ST_SHOW;
                    cur_d   = lowest_enabled(src_en);
                    dwell_d = '0;
                end
            end
            ST_SHOW: begin
                if (alert_req) begin
                    enter_alert = 1'b1;
                end else if (!src_en[cur_q]) begin
                    dwell_d = '0;
                    if (|src_en) cur_d = next_enabled(cur_q, src_en);
                    else         state_d = ST_IDLE;
                end else if (next_page || dwell_q == DWELL_LAST) begin
                    cur_d   = next_enabled(cur_q, src_en);
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_ALERT: begin
                // alert_req and next_page are deliberately not looked at while holding
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    dwell_d = '0;
                    if (src_en[cur_q]) begin
                        state_d = ST_SHOW;
                    end else if (|src_en) begin
                        state_d = ST_SHOW;
                        cur_d   = next_enabled(cur_q, src_en);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
`ifdef HEX_SCHED_BLINK_EN
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_ph_d  = ~blink_ph_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_alert) begin
            state_d     = ST_ALERT;
            hold_d      = '0;
            alert_val_d = alert_value;
            ack_d       = 1'b1;
`ifdef HEX_SCHED_BLINK_EN
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
`endif
        end

        // Outputs follow the next-state decision so the display lags it by exactly one register.
        src_d   = cur_d;
        word_d  = '0;
        valid_d = 1'b0;
        alert_d = 1'b0;
        case (state_d)
            ST_SHOW: begin
                word_d  = src_word[cur_d];
                valid_d = 1'b1;
            end
            ST_ALERT: begin
`ifdef HEX_SCHED_BLINK_EN
                word_d  = blink_ph_d ? 16'hEEEE : alert_val_d;
`else
                word_d  = alert_val_d;
`endif
                valid_d = 1'b1;
                alert_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            dwell_q     <= '0;
            hold_q      <= '0;
            alert_val_q <= '0;
            ack_q       <= 1'b0;
            word_q      <= '0;
            src_q       <= '0;
            alert_q     <= 1'b0;
            valid_q     <= 1'b0;
`ifdef HEX_SCHED_BLINK_EN
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            dwell_q     <= dwell_d;
            hold_q      <= hold_d;
            alert_val_q <= alert_val_d;
            ack_q       <= ack_d;
            word_q      <= word_d;
            src_q       <= src_d;
            alert_q     <= alert_d;
            valid_q     <= valid_d;
`ifdef HEX_SCHED_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
`endif
        end
    end

    assign alert_ack      = ack_q;
    assign disp_nibble[0] = word_q[3:0];
    assign disp_nibble[1] = word_q[7:4];
    assign disp_nibble[2] = word_q[11:8];
    assign disp_nibble[3] = word_q[15:12];
    assign disp_src       = src_q;
    assign disp_alert     = alert_q;
    assign disp_valid     = valid_q;

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Sequences what the 4-digit multiplexed hex display shows. Round-robins among NUM_SRC 16-bit status sources on a dwell timer, supports manual paging, and lets a one-shot alert pre-empt the display for a fixed hold time. The registered nibble outputs drive the four digit inputs of the hex display driver directly.

Parameters:
NUM_SRC, 4, number of 16-bit display sources (2..8)
DWELL_CYCLES, 50000000, clk cycles each source stays displayed
HOLD_CYCLES, 100000000, clk cycles an alert stays displayed
BLINK_CYCLES, 12500000, alert blink half-period (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
src_value  in  16*NUM_SRC  source values, flattened; source k occupies bits [16k+15:16k]
src_en  in  NUM_SRC  per-source enable; disabled sources are skipped
next_page  in  1  single-cycle pulse, already debounced; advances to the next source
alert_req  in  1  level request to show alert_value
alert_value  in  16  alert value, sampled on acceptance
alert_ack  out  1  one-cycle pulse when an alert is accepted
disp_nibble  out  4x4 (unpacked [4])  digit values; [0] is the rightmost digit
disp_src  out  $clog2(NUM_SRC)  index of the source shown
disp_alert  out  1  high while an alert is shown
disp_valid  out  1  low when nothing is enabled (IDLE)

Behaviour:
- Reset: synchronous, active-high; clock clk. All outputs are registered.
  - On reset: state=IDLE; disp_nibble all 0; disp_src=0; disp_alert=0; disp_valid=0; alert_ack=0; both timers 0.
  - Reset mid-alert or mid-dwell aborts immediately; no ack is produced.
- Nibble mapping: disp_nibble[i] = value[4i+3:4i].
- States:
  - IDLE: no src_en bit set.
    - If alert_req=1: go to ALERT (takes precedence).
    - Else, if any src_en bit is set: go to SHOW with cur = lowest enabled index; dwell=0.
  - SHOW: display src_value[cur] live, with 1-cycle latency; disp_valid=1. dwell increments every cycle.
    - Priority, highest first: alert_req > src_en[cur] dropped > next_page > dwell==DWELL_CYCLES-1.
    - Advance: cur = next enabled index after cur, wrapping from NUM_SRC-1 to 0. If cur is the only enabled source, cur is unchanged. dwell=0.
    - If src_en[cur] drops and no source is enabled: go to IDLE.
  - ALERT (entry):
    - Latch alert_value and pulse alert_ack on the entry transition cycle.
    - hold=0; disp_alert=1; disp_valid=1; disp_src keeps the pre-empted index.
  - ALERT (during): alert_req and next_page are ignored.
  - ALERT (exit): after HOLD_CYCLES cycles, return to SHOW with the same cur and dwell=0.
    - If cur is no longer enabled, advance; if nothing is enabled, go to IDLE.
  - Re-entry: a still-high alert_req is re-accepted one cycle after exit, with a new ack.
- Output timing: disp_* reflects the state and value chosen in the previous cycle, so output lags the decision by 1 cycle.
- Timers: widths are $clog2 of their limits. They are compared with ==, never wrap past the limit, and saturate-free by construction.

Optional Feature:
Macro: HEX_SCHED_BLINK_EN.
- Defined: during ALERT the display alternates every BLINK_CYCLES between the latched alert_value and 16'hEEEE, starting with alert_value. The blink counter resets on ALERT entry.
- Undefined: the display shows a static alert_value; BLINK_CYCLES is unused and no blink logic is present.

Test Plan:
Bench parameters for all scenarios: NUM_SRC=4, DWELL=8, HOLD=5, BLINK=2.
- Rotation: src_en=4'b1011, values 1111/2222/3333/4444 -> disp_src sequence 0,1,3,0. Each shown 8 cycles; disp_nibble[0] = 1,2,4,1.
- Manual paging and drop: next_page pulse at dwell=3 -> advance on the next cycle with dwell restarted. Clearing src_en[cur] -> advance one cycle later. src_en -> 0 -> disp_valid=0, disp_nibble=0.
- Alert pre-empt: alert_req with alert_value=16'hBEEF while showing src 1 -> single alert_ack. Nibbles F,E,E,B for 5 cycles, disp_alert=1, disp_src=1. Then src 1 resumes with a full 8-cycle dwell.
- Alert held high: alert_req held for 12 cycles -> two acks, separated by 6 cycles. next_page during ALERT has no effect.
- Reset mid-alert: reset asserted at hold=2 -> next cycle all outputs at reset values; no further ack.
- HEX_SCHED_BLINK_EN defined: alert 16'h1234 -> display shows 1234,1234,EEEE,EEEE,1234 over the 5 hold cycles.
